// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scanner: shifts one bit-plane per row, latches it, then shows it
// for a binary-weighted time. Define HUB75_BLANK_EN to add an OE-high gap before latch.
`timescale 1ns/1ps
module hub75_bcm_driver #(
    parameter int NUM_PIXELS      = 128,
    parameter int NUM_BLOCK_ROWS  = 16,
    parameter int COLOR_BITS      = 4,
    parameter int CLK_DIV         = 4,
    parameter int BASE_OE_CYCLES  = 8,
    parameter int LATCH_CYCLES    = 2,
    parameter int BLANK_CYCLES    = 4,
    localparam int LOG_ROWS       = $clog2(NUM_BLOCK_ROWS),
    localparam int PIXEL_SIZE     = 3 * COLOR_BITS,
    localparam int ADDR_W         = $clog2(NUM_BLOCK_ROWS * NUM_PIXELS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable,
    output logic [LOG_ROWS-1:0]   addr,
    output logic                  output_enable,
    output logic                  latch,
    output logic                  clk_drive,
    output logic [2:0]            rgb0,
    output logic [2:0]            rgb1,
    output logic                  pixel_rd_en,
    output logic [ADDR_W-1:0]     pixel_address,
    input  logic [PIXEL_SIZE-1:0] row_0_pixel_data,
    input  logic [PIXEL_SIZE-1:0] row_1_pixel_data,
    output logic                  frame_done
);

    localparam int HALF   = CLK_DIV / 2;
    localparam int DW     = $clog2(CLK_DIV);
    localparam int CLW    = $clog2(NUM_PIXELS + 1);
    localparam int PW     = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int OE_MAX = BASE_OE_CYCLES << (COLOR_BITS - 1);
    localparam int CW     = $clog2(OE_MAX + LATCH_CYCLES + BLANK_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t              state;
    logic [LOG_ROWS-1:0] row;
    logic [PW-1:0]       plane;
    logic [CLW-1:0]      col;
    logic [CLW-1:0]      rd_col;
    logic [DW-1:0]       div_cnt;
    logic [DW-1:0]       div_nxt;
    logic [CW-1:0]       cnt;
    logic                prime;
    logic                rd_q;
    logic                run_nxt;
    logic                rd_set;
    logic [COLOR_BITS-1:0] sel;
    logic [2:0]          bits0;
    logic [2:0]          bits1;

    function automatic logic [ADDR_W-1:0] row_base(input logic [LOG_ROWS-1:0] r);
        return ADDR_W'(r) * ADDR_W'(NUM_PIXELS);
    endfunction

    // Column c+1 is read during period c so its data lands exactly at the
    // period boundary; column 0 is fetched in a short lead-in with clock low.
    always_comb begin
        run_nxt = !prime || rd_q;
        div_nxt = '0;
        if (!prime && div_cnt != DW'(CLK_DIV - 1))
            div_nxt = div_cnt + 1'b1;
        rd_set = (state == SHIFT) && (rd_col != CLW'(NUM_PIXELS)) &&
                 ((prime && rd_col == '0) ||
                  (run_nxt && div_nxt == DW'(CLK_DIV - 2)));
        sel   = COLOR_BITS'(1) << plane;
        bits0 = {|(row_0_pixel_data[3*COLOR_BITS-1:2*COLOR_BITS] & sel),
                 |(row_0_pixel_data[2*COLOR_BITS-1:COLOR_BITS] & sel),
                 |(row_0_pixel_data[COLOR_BITS-1:0] & sel)};
        bits1 = {|(row_1_pixel_data[3*COLOR_BITS-1:2*COLOR_BITS] & sel),
                 |(row_1_pixel_data[2*COLOR_BITS-1:COLOR_BITS] & sel),
                 |(row_1_pixel_data[COLOR_BITS-1:0] & sel)};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            row           <= '0;
            plane         <= '0;
            col           <= '0;
            rd_col        <= '0;
            div_cnt       <= '0;
            cnt           <= '0;
            prime         <= 1'b0;
            rd_q          <= 1'b0;
            addr          <= '0;
            output_enable <= 1'b1;
            latch         <= 1'b0;
            clk_drive     <= 1'b0;
            rgb0          <= '0;
            rgb1          <= '0;
            pixel_rd_en   <= 1'b0;
            pixel_address <= '0;
            frame_done    <= 1'b0;
        end else begin
            pixel_rd_en <= 1'b0;
            frame_done  <= 1'b0;
            rd_q        <= pixel_rd_en;
            if (rd_q) begin
                rgb0 <= bits0;
                rgb1 <= bits1;
            end
            if (rd_set) begin
                pixel_rd_en   <= 1'b1;
                pixel_address <= row_base(row) + ADDR_W'(rd_col);
                rd_col        <= rd_col + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    output_enable <= 1'b1;
                    if (enable) begin
                        state <= SHIFT;
                        prime <= 1'b1;
                    end
                end

                SHIFT: begin
                    clk_drive <= !prime && (div_nxt >= DW'(HALF));
                    if (prime) begin
                        if (rd_q)
                            prime <= 1'b0;
                    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (col == CLW'(NUM_PIXELS - 1)) begin
                            col    <= '0;
                            rd_col <= '0;
                            addr   <= row;
`ifdef HUB75_BLANK_EN
                            state  <= BLANK;
                            cnt    <= CW'(BLANK_CYCLES);
`else
                            state  <= LATCH;
                            latch  <= 1'b1;
                            cnt    <= CW'(LATCH_CYCLES);
`endif
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                BLANK: begin
                    if (cnt == CW'(1)) begin
                        state <= LATCH;
                        latch <= 1'b1;
                        cnt   <= CW'(LATCH_CYCLES);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LATCH: begin
                    if (cnt == CW'(1)) begin
                        state         <= DISPLAY;
                        latch         <= 1'b0;
                        output_enable <= 1'b0;
                        cnt           <= CW'(BASE_OE_CYCLES) << plane;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DISPLAY: begin
                    // OE rises one cycle before leaving so the low time is exact
                    if (cnt == CW'(1)) begin
                        output_enable <= 1'b1;
                        cnt           <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (plane != PW'(COLOR_BITS - 1)) begin
                        plane <= plane + 1'b1;
                        state <= SHIFT;
                        prime <= 1'b1;
                    end else if (row != LOG_ROWS'(NUM_BLOCK_ROWS - 1)) begin
                        plane <= '0;
                        row   <= row + 1'b1;
                        state <= SHIFT;
                        prime <= 1'b1;
                    end else begin
                        plane      <= '0;
                        row        <= '0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
